// File: rtl/core101_mem_pkg.sv
// Shared definitions for the core101 memory responder: FSM state encodings
// and the default data/address width.
package core101_mem_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with registered read data.
module mem_array #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 1024,
   parameter     INIT_FILE = ""
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] idx,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Write-first is irrelevant here: the responder never reads and writes the same cycle.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
      rdata_q <= mem[idx];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Valid/ready memory responder: accepts one word request at a time, waits a
// configurable number of cycles, then performs the access and pulses ready.
// Macro MEM_WAIT_STATES_EN builds the WAIT state and counter; without it the
// latency is fixed at one edge and WAIT_CYCLES is ignored.
module data_mem_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter     INIT_FILE   = ""
) (
    input  logic            clock_in,
    input  logic            reset_in,
    input  logic            mem_valid_in,
    input  logic            mem_write_in,
    input  logic [XLEN-1:0] mem_addr_in,
    input  logic [XLEN-1:0] mem_data_in,
    output logic            mem_ready_out,
    output logic [XLEN-1:0] mem_data_out
);

    import core101_mem_pkg::*;

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t            state_q, state_d;
    logic              req_write_q, req_write_d;
    logic [XLEN-1:0]   req_addr_q, req_addr_d;
    logic [XLEN-1:0]   req_data_q, req_data_d;
    logic              ready_q, ready_d;
    logic [XLEN-1:0]   data_out_q, data_out_d;
`ifdef MEM_WAIT_STATES_EN
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`else
    localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

    logic [IDX_W-1:0]  ram_idx;
    logic              ram_we;
    logic [XLEN-1:0]   ram_rdata;
    logic              req_in_range;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^req_addr_q[1:0];

    // Any address bit above the index field marks the request out of range.
    assign req_in_range = ((req_addr_q >> (IDX_W + 2)) == '0);

    // The RAM reads the incoming index while idle so read data is ready by RESP.
    always_comb begin
        ram_idx = req_addr_q[IDX_W+1:2];
        if (state_q == IDLE) begin
            ram_idx = mem_addr_in[IDX_W+1:2];
        end
        ram_we = (state_q == RESP) && req_write_q && req_in_range;
    end

    mem_array #(
        .WIDTH     (XLEN),
        .DEPTH     (DEPTH_WORDS),
        .INIT_FILE (INIT_FILE)
    ) u_mem_array (
        .clk   (clock_in),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (req_data_q),
        .rdata (ram_rdata)
    );

    // Next-state logic: accept in IDLE, count down in WAIT, access and pulse ready in RESP.
    always_comb begin
        state_d     = state_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        ready_d     = 1'b0;
        data_out_d  = data_out_q;
`ifdef MEM_WAIT_STATES_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (mem_valid_in) begin
                    req_write_d = mem_write_in;
                    req_addr_d  = mem_addr_in;
                    req_data_d  = mem_data_in;
`ifdef MEM_WAIT_STATES_EN
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
`else
                    state_d = RESP;
`endif
                end
            end
`ifdef MEM_WAIT_STATES_EN
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
`endif
            RESP: begin
                ready_d = 1'b1;
                if (!req_write_q) begin
                    data_out_d = req_in_range ? ram_rdata : '0;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register FSM state, request fields and the response outputs.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q     <= IDLE;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            ready_q     <= 1'b0;
            data_out_q  <= '0;
`ifdef MEM_WAIT_STATES_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            ready_q     <= ready_d;
            data_out_q  <= data_out_d;
`ifdef MEM_WAIT_STATES_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign mem_ready_out = ready_q;
    assign mem_data_out  = data_out_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: the driver pushes the expected
// response when a request is accepted, the monitor pops on every ready pulse.
module tb_data_mem_responder;

`ifdef MEM_WAIT_STATES_EN
    localparam int EFF_WAIT = 2;
`else
    localparam int EFF_WAIT = 0;
`endif

    typedef struct {
        logic [31:0] data;
        int          accept_cyc;
        string       name;
    } exp_t;

    logic        clock_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        mem_valid_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic [31:0] mem_addr_in = '0;
    logic [31:0] mem_data_in = '0;
    logic        mem_ready_out;
    logic [31:0] mem_data_out;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] model_data = '0;
    exp_t        exp_q[$];

    data_mem_responder #(
        .XLEN        (32),
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (2)
    ) dut (
        .clock_in      (clock_in),
        .reset_in      (reset_in),
        .mem_valid_in  (mem_valid_in),
        .mem_write_in  (mem_write_in),
        .mem_addr_in   (mem_addr_in),
        .mem_data_in   (mem_data_in),
        .mem_ready_out (mem_ready_out),
        .mem_data_out  (mem_data_out)
    );

    // Free-running clock and edge counter used for latency checks.
    always #5 clock_in = ~clock_in;
    always @(posedge clock_in) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Issue one request, push its expected response, and wait (bounded) for ready.
    task automatic applyStimulus(input string name, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rexp, input bit abort);
        exp_t e;
        bit   seen = 0;
        mem_valid_in = 1'b1;
        mem_write_in = wr;
        mem_addr_in  = addr;
        mem_data_in  = wdata;
        @(posedge clock_in);
        #1;
        e.data       = wr ? model_data : rexp;
        e.accept_cyc = cyc;
        e.name       = name;
        model_data   = e.data;
        exp_q.push_back(e);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock_in);
            if (mem_ready_out) begin
                seen = 1;
                break;
            end
            if (abort) mem_valid_in = 1'b0;
        end
        mem_valid_in = 1'b0;
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout actual=no_ready expected=ready", name);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clock_in) begin
        if (mem_ready_out) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput({e.name, "_data"}, mem_data_out, e.data);
                checkOutput({e.name, "_latency"}, 32'(cyc - e.accept_cyc), 32'(1 + EFF_WAIT));
            end
        end
    end

    initial begin
        // Reset, then idle with no requests.
        repeat (3) @(negedge clock_in);
        checkOutput("reset_ready", {31'd0, mem_ready_out}, 32'd0);
        checkOutput("reset_data", mem_data_out, 32'd0);
        reset_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock_in);
            checkOutput("idle_ready", {31'd0, mem_ready_out}, 32'd0);
            checkOutput("idle_data", mem_data_out, 32'd0);
        end

        applyStimulus("wr_10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        applyStimulus("rd_10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        applyStimulus("wr_10b", 1'b1, 32'h10, 32'h12345678, 32'h0, 0);
        applyStimulus("rd_13", 1'b0, 32'h13, 32'h0, 32'h12345678, 0);

        // Out-of-range accesses must neither alias onto RAM[0] nor return data.
        applyStimulus("wr_0", 1'b1, 32'h0, 32'hCAFEF00D, 32'h0, 0);
        applyStimulus("wr_1000", 1'b1, 32'h1000, 32'hBAD0BAD0, 32'h0, 0);
        applyStimulus("rd_1000", 1'b0, 32'h1000, 32'h0, 32'h0, 0);
        applyStimulus("rd_0", 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 0);
        applyStimulus("rd_hi", 1'b0, 32'h80000000, 32'h0, 32'h0, 0);

        // Top word of the array.
        applyStimulus("wr_ffc", 1'b1, 32'hFFC, 32'h0F0F0F0F, 32'h0, 0);
        applyStimulus("rd_ffc", 1'b0, 32'hFFC, 32'h0, 32'h0F0F0F0F, 0);

        // Valid dropped after acceptance: access still completes.
        applyStimulus("wr_20_abort", 1'b1, 32'h20, 32'hA5A5A5A5, 32'h0, 1);
        applyStimulus("rd_20", 1'b0, 32'h20, 32'h0, 32'hA5A5A5A5, 0);

        // Reset during a pending write to 0x24: no commit, no ready.
        applyStimulus("wr_24", 1'b1, 32'h24, 32'h11112222, 32'h0, 0);
        mem_valid_in = 1'b1;
        mem_write_in = 1'b1;
        mem_addr_in  = 32'h24;
        mem_data_in  = 32'h99999999;
        @(posedge clock_in);
        #2;
        reset_in     = 1'b0;
        mem_valid_in = 1'b0;
        #1;
        checkOutput("midreset_ready", {31'd0, mem_ready_out}, 32'd0);
        checkOutput("midreset_data", mem_data_out, 32'd0);
        model_data = '0;
        repeat (3) @(negedge clock_in);
        reset_in = 1'b1;
        repeat (4) @(negedge clock_in);
        checkOutput("postreset_ready", {31'd0, mem_ready_out}, 32'd0);
        applyStimulus("rd_24", 1'b0, 32'h24, 32'h0, 32'h11112222, 0);

        repeat (5) @(negedge clock_in);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
